// File: rtl/dc_axi_rd_responder.sv
// AXI read responder: queues AR requests, waits a fixed latency, then
// returns an INCR burst whose data is the byte address of each beat.
module dc_axi_rd_responder #(
  parameter int unsigned ID_W   = 16,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ID_W-1:0]              arid_i,
  input  logic [ADDR_W-1:0]            araddr_i,
  input  logic [7:0]                   arlen_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [ID_W-1:0]              rid_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rlast_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [$clog2(DEPTH+1)-1:0]   req_cnt_o
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LAT_W  = 4;
  localparam int unsigned BEAT_W = 9;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  req_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  req_t              head;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_nxt;
  logic [BEAT_W-1:0] beat_nxt;
  logic              rvalid_d, rlast_d;
  logic [ID_W-1:0]   rid_d;
  logic [DATA_W-1:0] rdata_d;

  // Accept decode uses registered occupancy only, so a pop never frees a slot on the same edge
  assign arready_o = (count != CNT_W'(DEPTH));
  assign push      = arvalid_i && arready_o;
  assign head      = mem[rd_ptr];
  assign req_cnt_o = count;
  assign rresp_o   = 2'b00;
  assign addr_nxt  = addr_q + STRIDE;
  assign beat_nxt  = beat_q + BEAT_W'(1);

  // Request storage (contents need no reset; pointers qualify them)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: arid_i, addr: araddr_i, len: arlen_i};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Service FSM state and registered R channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      beat_q   <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      rvalid_o <= 1'b0;
      rlast_o  <= 1'b0;
      rid_o    <= '0;
      rdata_o  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rvalid_o <= rvalid_d;
      rlast_o  <= rlast_d;
      rid_o    <= rid_d;
      rdata_o  <= rdata_d;
    end
  end

  // Next-state: pop -> latency wait -> beats; R outputs hold unless a beat is accepted
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rvalid_d = rvalid_o;
    rlast_d  = rlast_o;
    rid_d    = rid_o;
    rdata_d  = rdata_o;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop    = 1'b1;
          id_d   = head.id;
          addr_d = head.addr;
          len_d  = head.len;
          beat_d = '0;
          if (RD_LAT == 0) begin
            state_d  = S_BURST;
            rvalid_d = 1'b1;
            rid_d    = head.id;
            rdata_d  = DATA_W'(head.addr);
            rlast_d  = (head.len == 8'd0);
          end else begin
            state_d = S_WAIT;
            lat_d   = LAT_W'(RD_LAT);
          end
        end
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d  = S_BURST;
          rvalid_d = 1'b1;
          rid_d    = id_q;
          rdata_d  = DATA_W'(addr_q);
          rlast_d  = (len_q == 8'd0);
        end
      end
      S_BURST: begin
        if (rready_i) begin
          if (beat_q == BEAT_W'(len_q)) begin
            state_d  = S_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            beat_d  = beat_nxt;
            addr_d  = addr_nxt;
            rdata_d = DATA_W'(addr_nxt);
            rlast_d = (beat_nxt == BEAT_W'(len_q));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dc_axi_rd_responder.sv
// Bench for dc_axi_rd_responder: inputs change on the falling edge, outputs
// are sampled there too, and every R beat is matched against a queue of
// beats expanded from accepted requests.
module tb_dc_axi_rd_responder;

  localparam int unsigned RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] arid_i;
  logic [63:0] araddr_i;
  logic [7:0]  arlen_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [15:0] rid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [2:0]  req_cnt_o;

  dc_axi_rd_responder #(
    .ID_W(16), .ADDR_W(64), .DATA_W(64), .DEPTH(4), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .req_cnt_o(req_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int rr_mode = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never
  int phase = 0;
  int beats_seen = 0;
  int lasts_seen = 0;
  bit ar_acc = 0;
  bit stall_prev = 0;
  logic [15:0] prev_id;
  logic [63:0] prev_data;
  logic        prev_last;
  bit gap_chk = 0, gap_run = 0;
  int gap_n = 0;
  bit lat_arm = 0, lat_run = 0;
  int lat_n = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: pick rready, score this cycle's handshakes, advance to the next falling edge
  task automatic cycle();
    beat_t e;
    case (rr_mode)
      0: rready_i = 1'b1;
      1: begin rready_i = (phase % 4 == 0) || (phase % 4 == 3); phase++; end
      2: rready_i = ($urandom % 4) != 0;
      default: rready_i = 1'b0;
    endcase
    if (stall_prev) begin
      check("stall_rvalid", rvalid_o, 1);
      check("stall_rid", rid_o, prev_id);
      check("stall_rdata", rdata_o, prev_data);
      check("stall_rlast", rlast_o, prev_last);
    end
    if (gap_run) begin
      if (rvalid_o) begin
        if (gap_chk) check("burst_gap", gap_n, 1 + RD_LAT);
        gap_run = 0;
      end else gap_n++;
    end
    if (lat_run) begin
      lat_n++;
      if (rvalid_o) begin
        check("first_beat_latency", lat_n, RD_LAT + 2);
        lat_run = 0;
      end
    end
    if (rvalid_o && rready_i) begin
      if (exp_q.size() == 0) check("unexpected_beat", rvalid_o, 0);
      else begin
        e = exp_q.pop_front();
        check("rid", rid_o, e.id);
        check("rdata", rdata_o, e.data);
        check("rlast", rlast_o, e.last);
        check("rresp", rresp_o, 0);
        beats_seen++;
        if (rlast_o) begin
          lasts_seen++;
          gap_run = 1;
          gap_n = 0;
        end
      end
    end
    ar_acc = arvalid_i && arready_o;
    if (ar_acc) begin
      for (int i = 0; i <= int'(arlen_i); i++) begin
        e.id   = arid_i;
        e.data = araddr_i + 64'(i) * 64'd8;
        e.last = (i == int'(arlen_i));
        exp_q.push_back(e);
      end
      if (lat_arm) begin
        lat_run = 1;
        lat_n = 0;
        lat_arm = 0;
      end
    end
    stall_prev = rvalid_o && !rready_i;
    prev_id = rid_o;
    prev_data = rdata_o;
    prev_last = rlast_o;
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                      input int bound, output bit ok);
    int n;
    n = 0;
    arid_i = id; araddr_i = addr; arlen_i = len; arvalid_i = 1'b1;
    ar_acc = 0;
    while (!ar_acc && n < bound) begin
      cycle();
      n++;
    end
    arvalid_i = 1'b0;
    ok = ar_acc;
  endtask

  task automatic send_chk(input string tag, input logic [15:0] id, input logic [63:0] addr,
                          input logic [7:0] len);
    bit ok;
    send(id, addr, len, 300, ok);
    check({tag, "_accept"}, ok, 1);
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (3) cycle();
    check({tag, "_idle_rvalid"}, rvalid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    int b0, l0, n;

    rst_n = 1'b0; arvalid_i = 1'b0; rready_i = 1'b0;
    arid_i = '0; araddr_i = '0; arlen_i = '0;
    repeat (2) @(negedge clk);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rlast", rlast_o, 0);
    check("rst_rid", rid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_rresp", rresp_o, 0);
    check("rst_req_cnt", req_cnt_o, 0);
    check("rst_arready", arready_o, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single burst with latency measurement
    rr_mode = 0;
    lat_arm = 1;
    send_chk("single", 16'd7, 64'h1000, 8'd3);
    drain("single", 100);

    // Three back-to-back bursts; gap between bursts measured
    gap_run = 0;
    gap_chk = 1;
    send_chk("b2b0", 16'd7, 64'heeee_eeee_eeee_eeee, 8'd10);
    send_chk("b2b1", 16'd5, 64'h0, 8'd10);
    send_chk("b2b2", 16'd3, 64'h0000_0ccc_cccc_cccc, 8'd10);
    drain("b2b", 200);
    gap_chk = 0;

    // Backpressure pattern 1,0,0,1
    rr_mode = 1;
    phase = 0;
    for (int k = 0; k < 3; k++)
      send_chk("bp", 16'($urandom), {$urandom, $urandom}, 8'($urandom_range(1, 6)));
    drain("bp", 400);

    // Full FIFO: one in service plus DEPTH queued
    rr_mode = 3;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      send(16'(k + 1), 64'(k) * 64'h100, 8'($urandom_range(0, 3)), 3, ok);
      acc += int'(ok);
    end
    check("full_accepted", acc, 5);
    check("full_arready", arready_o, 0);
    check("full_req_cnt", req_cnt_o, 4);
    rr_mode = 0;
    l0 = lasts_seen;
    n = 0;
    while (lasts_seen == l0 && n < 50) begin
      cycle();
      n++;
    end
    check("full_first_done", lasts_seen, l0 + 1);
    check("full_arready_pre_pop", arready_o, 0);
    cycle();
    check("full_arready_after_pop", arready_o, 1);
    check("full_req_cnt_after_pop", req_cnt_o, 3);
    drain("full", 200);

    // Address wrap and maximum burst length
    send_chk("wrap", 16'h00a1, 64'hffff_ffff_ffff_fff8, 8'd1);
    drain("wrap", 50);
    send_chk("maxlen", 16'h00ff, 64'h0000_1234_0000_0000, 8'd255);
    drain("maxlen", 400);
    check("maxlen_beats", beats_seen >= 256, 1);

    // Randomised traffic with random backpressure
    rr_mode = 2;
    for (int k = 0; k < 30; k++) begin
      send_chk("rand", 16'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) cycle();
    end
    drain("rand", 3000);

    // Reset during beat 3 of an 11-beat burst with two requests queued
    rr_mode = 0;
    send_chk("rstmid0", 16'h11, 64'h4000, 8'd10);
    send_chk("rstmid1", 16'h22, 64'h5000, 8'd10);
    send_chk("rstmid2", 16'h33, 64'h6000, 8'd10);
    b0 = beats_seen;
    n = 0;
    while (beats_seen < b0 + 2 && n < 50) begin
      cycle();
      n++;
    end
    check("rstmid_in_burst", rvalid_o, 1);
    check("rstmid_queued", req_cnt_o, 2);
    rst_n = 1'b0;
    #1;
    check("rstmid_rvalid", rvalid_o, 0);
    check("rstmid_rlast", rlast_o, 0);
    check("rstmid_req_cnt", req_cnt_o, 0);
    check("rstmid_arready", arready_o, 1);
    exp_q.delete();
    stall_prev = 0; gap_run = 0; lat_run = 0; lat_arm = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cycle();
    check("post_rst_rvalid", rvalid_o, 0);
    check("post_rst_req_cnt", req_cnt_o, 0);
    lat_arm = 1;
    send_chk("post_rst", 16'h44, 64'h7000, 8'd2);
    drain("post_rst", 100);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
